serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width in bits; legal range >= 1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  DATA_WIDTH  minuend, unsigned.
REQ-007 SHALL have port b  input  DATA_WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port out_valid  output  1  diff/borrow hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port diff  output  DATA_WIDTH  (a - b) mod 2^DATA_WIDTH.
REQ-011 SHALL have port borrow  output  1  borrow out of the MSB; 1 iff a < b unsigned.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid && in_ready, SHALL latch a and b, clear internal borrow and bit counter, and go to RUN; otherwise stay in IDLE.
REQ-015 RUN: SHALL process one bit per cycle, LSB first: d = a[i]^b[i]^bin; bout = (~a[i]&b[i]) | (~(a[i]^b[i])&bin).
REQ-016 RUN: SHALL shift d into the result register from the MSB side, so bit i lands at diff[i] after the final step.
REQ-017 RUN: bit counter width SHALL be max(1, $clog2(DATA_WIDTH)); go to DONE on the edge that processes bit DATA_WIDTH-1.
REQ-018 Latency: out_valid SHALL rise exactly DATA_WIDTH clock edges after the accepting edge. DATA_WIDTH=1 gives 1 RUN cycle.
REQ-019 DONE: diff and borrow SHALL hold stable while out_valid && !out_ready, for any number of cycles.
REQ-020 DONE: on out_valid && out_ready, SHALL return to IDLE. in_ready SHALL rise on the following cycle, with no same-cycle re-accept.
REQ-021 in_valid, a and b SHALL be ignored in RUN and DONE. Latched operands SHALL be unaffected by input changes after acceptance.
REQ-022 diff and borrow SHALL be undefined-free: they keep the last completed result, or reset values, whenever out_valid = 0.
REQ-023 Wrap-around: results SHALL be modulo 2^DATA_WIDTH. The borrow out of the MSB SHALL appear only on borrow, never widening diff.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid = 0, diff = 0, borrow = 0, counter = 0, and internal borrow = 0.
REQ-025 in_ready SHALL read 1 while in reset and after release, since the FSM is in IDLE.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no partial result visible. The first accept after release SHALL compute correctly.

Verification
REQ-027 DATA_WIDTH=8, a=0x35, b=0x12 accepted at edge T -> out_valid at T+8, diff=0x23, borrow=0.
REQ-028 DATA_WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=b=0xA5 -> diff=0x00, borrow=0.
REQ-029 Backpressure: out_ready held low 5 cycles in DONE, with in_valid=1 and new a/b toggled -> diff/borrow constant, in_ready=0, no new accept. out_ready=1 -> IDLE, then in_ready=1 on the next cycle.
REQ-030 Reset mid-RUN at bit 3 -> out_valid=0, diff=0, borrow=0 immediately. After release, a=0x80, b=0x7F -> diff=0x01, borrow=0.
REQ-031 DATA_WIDTH=1, all four a/b combos -> (0,0):0/0, (1,0):1/0, (0,1):1/1, (1,1):0/0, each with out_valid 1 edge after accept.
REQ-032 Random back-to-back: 1000 pairs with random in_valid/out_ready gaps -> every result matches a-b mod 256 plus a<b, with no lost or duplicated results.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts an operand pair, then computes a - b
// one bit per clock (LSB first) and presents diff/borrow under a valid/ready handshake.
module serial_subtractor #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_borrow;
  logic                  r_bin;
  logic [CW-1:0]         r_cnt;

  logic                  w_accept;
  logic                  w_run;
  logic                  w_last;
  logic                  w_d;
  logic                  w_bout;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // One-bit full subtractor on the current LSBs; the new difference bit enters from the MSB side.
  always_comb begin
    w_d         = r_a[0] ^ r_b[0] ^ r_bin;
    w_bout      = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);
    w_shift_nxt = r_shift >> 1;
    w_shift_nxt[DATA_WIDTH-1] = w_d;
  end

  // Next-state logic and handshake qualifiers.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; in_ready/out_valid are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture, serial datapath, and result publication on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_shift  <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_bin <= 1'b0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_bin   <= w_bout;
      r_shift <= w_shift_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= w_shift_nxt;
        r_borrow <= w_bout;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle model for the 8-bit instance plus directed literal checks
// (including a 1-bit instance), followed by a randomised back-to-back run.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] diff;
  logic       borrow;

  logic       p_in_valid = 1'b0;
  logic       p_in_ready;
  logic [0:0] p_a = '0;
  logic [0:0] p_b = '0;
  logic       p_out_valid;
  logic       p_out_ready = 1'b0;
  logic [0:0] p_diff;
  logic       p_borrow;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.DATA_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .a(p_a), .b(p_b),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .diff(p_diff), .borrow(p_borrow)
  );

  always #5 clk = ~clk;

  // Transaction-level model of the 8-bit instance: idle / busy for 8 edges / holding a result.
  bit       m_idle = 1'b1;
  bit       m_done = 1'b0;
  int       m_left = 0;
  bit [7:0] m_diff = '0;
  bit       m_borrow = 1'b0;
  bit [7:0] m_pend_d = '0;
  bit       m_pend_b = 1'b0;
  int       n_acc = 0;
  int       n_del = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0; m_diff = '0; m_borrow = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_pend_d = 8'((int'(a) - int'(b) + 256) % 256);
        m_pend_b = (a < b);
        m_idle   = 1'b0;
        m_left   = 8;
        n_acc++;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_diff = m_pend_d; m_borrow = m_pend_b;
      end
    end else if (m_done && out_ready) begin
      m_done = 1'b0; m_idle = 1'b1; n_del++;
    end
  end

  // Compare the 8-bit instance with the model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (in_ready !== m_idle || out_valid !== m_done || diff !== m_diff || borrow !== m_borrow) begin
        n_err++;
        $display("FAIL monitor t=%0t in_ready %b/%b out_valid %b/%b diff %h/%h borrow %b/%b (got/expected)",
                 $time, in_ready, m_idle, out_valid, m_done, diff, m_diff, borrow, m_borrow);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed 8-bit operation with literal expectations, optional backpressure cycles in DONE.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] ed, input logic eb, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = va; b = vb;
    tick();
    in_valid = 1'b0; a = ~va; b = ~vb;
    repeat (7) tick();
    chk("latency_early", 32'(out_valid), 32'd0);
    tick();
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow", 32'(borrow), 32'(eb));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      tick();
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_borrow", 32'(borrow), 32'(eb));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Directed operation on the 1-bit instance.
  task automatic do_op1(input logic va, input logic vb, input logic ed, input logic eb);
    int n;
    n = 0;
    while (!p_in_ready && n < 100) begin tick(); n++; end
    chk("w1_ready_wait", 32'(p_in_ready), 32'd1);
    p_in_valid = 1'b1; p_a = va; p_b = vb;
    tick();
    p_in_valid = 1'b0; p_a = ~va; p_b = ~vb;
    chk("w1_not_yet", 32'(p_out_valid), 32'd0);
    tick();
    chk("w1_valid", 32'(p_out_valid), 32'd1);
    chk("w1_diff", 32'(p_diff), 32'(ed));
    chk("w1_borrow", 32'(p_borrow), 32'(eb));
    p_out_ready = 1'b1;
    tick();
    p_out_ready = 1'b0;
    chk("w1_release", 32'(p_out_valid), 32'd0);
  endtask

  initial begin
    int acc0, del0, cyc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_w1_in_ready", 32'(p_in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    do_op(8'h35, 8'h12, 8'h23, 1'b0, 0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 0);
    do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 0);
    do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 0);
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 0);
    do_op(8'h12, 8'h35, 8'hDD, 1'b1, 5);

    // Abort during RUN while bit 3 is being processed; previous result is nonzero.
    do_op(8'h5A, 8'h10, 8'h4A, 1'b0, 0);
    in_valid = 1'b1; a = 8'h33; b = 8'h11;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    do_op(8'h80, 8'h7F, 8'h01, 1'b0, 0);

    do_op1(1'b0, 1'b0, 1'b0, 1'b0);
    do_op1(1'b1, 1'b0, 1'b1, 1'b0);
    do_op1(1'b0, 1'b1, 1'b1, 1'b1);
    do_op1(1'b1, 1'b1, 1'b0, 1'b0);

    // Random back-to-back traffic with gaps on both sides of the handshake.
    acc0 = n_acc; del0 = n_del; cyc = 0;
    while ((n_del - del0) < 1000 && cyc < 40000) begin
      in_valid  = ((n_acc - acc0) < 1000) && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_accepted", 32'(n_acc - acc0), 32'd1000);
    chk("rand_delivered", 32'(n_del - del0), 32'd1000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
